// File: rtl/sqrt_msq_acc.sv
// rtl/sqrt_msq_acc.sv - mean-square accumulator feeding the SQRT stage
//
// Purpose:
//   Squares a stream of signed Q4.4 samples. Sums 2^LOG2N consecutive squares.
//   Emits their mean as an unsigned Q8.8 word with a one-cycle valid strobe.
//   The output is held between windows so a downstream iterative square root
//   can converge on it.
//
// Parameters:
//   LOG2N          log2 of the window length N (legal range 0..8)
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   clear_i        synchronous window abort; also drops the same-edge sample
//   sample_valid_i sample_i is valid this cycle
//   sample_i       signed two's-complement Q4.4 sample
//   data_o         unsigned Q8.8 mean of squares, held between windows
//   data_valid_o   one-cycle pulse when data_o updates
//   busy_o         window partially accumulated or a square in flight
//
// Build option:
//   MSQ_ROUND_EN   when defined, the mean is rounded half-up instead of truncated

module sqrt_msq_acc #(
  parameter int LOG2N = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        sample_valid_i,
  input  logic [7:0]  sample_i,
  output logic [15:0] data_o,
  output logic        data_valid_o,
  output logic        busy_o
);

  // The accumulator carries LOG2N guard bits, so a full window of 0x4000
  // squares cannot overflow it.
  localparam int AW = 16 + LOG2N;
  // With LOG2N=0 there is no real counter. A 1-bit register is kept so the
  // code stays uniform; it never leaves zero in that case.
  localparam int CW = (LOG2N > 0) ? LOG2N : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2N) - 1);

`ifdef MSQ_ROUND_EN
  // Half an LSB of the shifted result. (1<<LOG2N)>>1 is 0 for LOG2N=0.
  localparam logic [AW-1:0] RND = AW'((1 << LOG2N) >> 1);
`else
  localparam logic [AW-1:0] RND = '0;
`endif

  // Stage 1 registers: the square and its valid flag
  logic [15:0]   sq_q, sq_d;
  logic          sq_v_q, sq_v_d;

  // Stage 2 registers: the running sum, the window position and the output
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   data_q, data_d;
  logic          dv_q, dv_d;

  // Sign-extend to 16 bits before multiplying. The low 16 bits of the product
  // are then the exact square. The largest square is (-128)^2 = 0x4000, so the
  // result is always non-negative in Q8.8.
  logic signed [15:0] sample_ext;
  logic signed [15:0] square;

  assign sample_ext = {{8{sample_i[7]}}, sample_i};
  assign square     = sample_ext * sample_ext;

  logic          win_last;
  logic [AW-1:0] acc_sum;
  logic [AW-1:0] mean_full;

  assign win_last  = (LOG2N == 0) ? 1'b1 : (cnt_q == CNT_LAST);
  assign acc_sum   = acc_q + AW'(sq_q);
  assign mean_full = (acc_sum + RND) >> LOG2N;

  always_comb begin
    sq_d   = sq_q;
    sq_v_d = 1'b0;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    dv_d   = 1'b0;

    if (clear_i) begin
      // The square in flight and the sample on this edge are both dropped.
      // data_o keeps its last value.
      acc_d  = '0;
      cnt_d  = '0;
    end else begin
      if (sample_valid_i) begin
        sq_d   = 16'(square);
        sq_v_d = 1'b1;
      end

      if (sq_v_q) begin
        if (win_last) begin
          // Completing edge. Clearing acc here lets the next window's first
          // square land without a bubble.
          data_d = mean_full[15:0];
          dv_d   = 1'b1;
          acc_d  = '0;
          cnt_d  = '0;
        end else begin
          acc_d  = acc_sum;
          cnt_d  = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sq_q   <= '0;
      sq_v_q <= 1'b0;
      acc_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      dv_q   <= 1'b0;
    end else begin
      sq_q   <= sq_d;
      sq_v_q <= sq_v_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      dv_q   <= dv_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = dv_q;
  assign busy_o       = sq_v_q | (cnt_q != '0);

endmodule

// File: tb/tb_sqrt_msq_acc.sv
// tb/tb_sqrt_msq_acc.sv - self-checking bench for sqrt_msq_acc (LOG2N=2 and LOG2N=0)

module tb_sqrt_msq_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        sv;
  logic [7:0]  smp;
  logic [15:0] d2, d0;
  logic        v2, b2, v0, b0;

  always #5 clk = ~clk;

  sqrt_msq_acc #(.LOG2N(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .sample_valid_i(sv),
    .sample_i(smp), .data_o(d2), .data_valid_o(v2), .busy_o(b2)
  );

  sqrt_msq_acc #(.LOG2N(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .sample_valid_i(sv),
    .sample_i(smp), .data_o(d0), .data_valid_o(v0), .busy_o(b0)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model, one slot per instance: [0] is LOG2N=2, [1] is LOG2N=0.
  // It keeps a plain integer sum and count for each window, plus the one
  // square that is still on its way to the accumulator.
  int          lg [2] = '{2, 0};
  int          msum [2];
  int          mcnt [2];
  bit          mpv [2];
  int          mpsq [2];
  logic [15:0] mout [2];
  bit          mval [2];

  wire [35:0] act_vec = {d2, v2, b2, d0, v0, b0};

  function automatic logic [35:0] exp_vec();
    return {mout[0], mval[0], (mpv[0] || mcnt[0] != 0),
            mout[1], mval[1], (mpv[1] || mcnt[1] != 0)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      msum[i] = 0; mcnt[i] = 0; mpv[i] = 0; mpsq[i] = 0;
      mout[i] = 16'h0000; mval[i] = 0;
    end
  endtask

  task automatic model_edge();
    int n, rnd, s;
    s = int'($signed(smp));
    for (int i = 0; i < 2; i++) begin
      n = 1 << lg[i];
`ifdef MSQ_ROUND_EN
      rnd = n / 2;
`else
      rnd = 0;
`endif
      mval[i] = 0;
      if (clear) begin
        msum[i] = 0; mcnt[i] = 0; mpv[i] = 0;
      end else begin
        if (mpv[i]) begin
          msum[i] += mpsq[i];
          mcnt[i]++;
          if (mcnt[i] == n) begin
            mout[i] = 16'((msum[i] + rnd) / n);
            mval[i] = 1;
            msum[i] = 0; mcnt[i] = 0;
          end
        end
        mpv[i]  = sv;
        mpsq[i] = s * s;
      end
    end
  endtask

  task automatic apply(input bit c, input bit v, input logic [7:0] s);
    clear = c; sv = v; smp = s;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; sv = 1'b1; smp = 8'h7F;
    model_reset();
    #12;
    vectors++;
    if (act_vec !== 36'h0) begin
      miscompares++;
      $display("FAIL reset_state: got %h want %h", act_vec, 36'h0);
    end
    #10;
    rst_n = 1'b1; sv = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, i < 4, 8'h20);
      vectors++;
      if (act_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL b2b_cycle%0d: got %h want %h", i, act_vec, exp_vec());
      end
      if (i == 4) begin
        vectors++;
        if ({v2, d2} !== {1'b1, 16'h0400}) begin
          miscompares++;
          $display("FAIL b2b_result: got v=%b d=%h want v=1 d=0400", v2, d2);
        end
      end
      if (i == 5) begin
        vectors++;
        if ({v2, b2} !== 2'b00) begin
          miscompares++;
          $display("FAIL b2b_idle: got v=%b busy=%b want 0 0", v2, b2);
        end
      end
    end
  endtask

  task automatic test_gaps();
    int pulses = 0;
    for (int i = 0; i < 14; i++) begin
      apply(1'b0, (i % 3) == 0 && i < 12, 8'h80);
      if (v2) pulses++;
      vectors++;
      if (act_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL gaps_cycle%0d: got %h want %h", i, act_vec, exp_vec());
      end
    end
    vectors++;
    if (pulses !== 1 || d2 !== 16'h4000) begin
      miscompares++;
      $display("FAIL gaps_result: got pulses=%0d d=%h want 1 4000", pulses, d2);
    end
  endtask

  task automatic test_rounding();
    logic [7:0]  seq [4] = '{8'h10, 8'h10, 8'h11, 8'h11};
    logic [15:0] want;
`ifdef MSQ_ROUND_EN
    want = 16'h0111;
`else
    want = 16'h0110;
`endif
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, i < 4, (i < 4) ? seq[i] : 8'h00);
      vectors++;
      if (act_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL round_cycle%0d: got %h want %h", i, act_vec, exp_vec());
      end
    end
    vectors++;
    if ({v2, d2} !== {1'b1, want}) begin
      miscompares++;
      $display("FAIL round_result: got v=%b d=%h want v=1 d=%h", v2, d2, want);
    end
  endtask

  task automatic test_back_to_back_windows();
    int p1 = -1, p2 = -1;
    logic [15:0] o1 = 16'h0, o2 = 16'h0;
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, i < 8, (i < 4) ? 8'h20 : 8'h30);
      if (v2) begin
        if (p1 < 0) begin p1 = i; o1 = d2; end
        else begin p2 = i; o2 = d2; end
      end
      vectors++;
      if (act_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL seam_cycle%0d: got %h want %h", i, act_vec, exp_vec());
      end
    end
    vectors++;
    if (p1 !== 4 || p2 !== 8 || o1 !== 16'h0400 || o2 !== 16'h0900) begin
      miscompares++;
      $display("FAIL seam_result: got at %0d/%0d d=%h/%h want at 4/8 d=0400/0900",
               p1, p2, o1, o2);
    end
  endtask

  task automatic test_clear();
    apply(1'b0, 1'b1, 8'h20);
    apply(1'b0, 1'b1, 8'h20);
    // The sample presented with CLEAR must be dropped as well
    apply(1'b1, 1'b1, 8'h7F);
    vectors++;
    if ({d2, v2, b2} !== {16'h0900, 1'b0, 1'b0} || act_vec !== exp_vec()) begin
      miscompares++;
      $display("FAIL clear_hold: got %h want %h (d2 0900)", act_vec, exp_vec());
    end
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, i < 4, 8'h10);
      vectors++;
      if (act_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL clear_cycle%0d: got %h want %h", i, act_vec, exp_vec());
      end
    end
    vectors++;
    if ({v2, d2} !== {1'b1, 16'h0100}) begin
      miscompares++;
      $display("FAIL clear_result: got v=%b d=%h want v=1 d=0100", v2, d2);
    end
  endtask

  task automatic test_reset_mid_window();
    apply(1'b0, 1'b1, 8'h20);
    apply(1'b0, 1'b1, 8'h20);
    sv = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (act_vec !== 36'h0) begin
      miscompares++;
      $display("FAIL reset_mid: got %h want %h", act_vec, 36'h0);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (act_vec !== 36'h0) begin
      miscompares++;
      $display("FAIL reset_mid_hold: got %h want %h", act_vec, 36'h0);
    end
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_log2n0();
    apply(1'b0, 1'b1, 8'hF0);
    apply(1'b0, 1'b0, 8'h00);
    vectors++;
    if ({v0, d0} !== {1'b1, 16'h0100} || act_vec !== exp_vec()) begin
      miscompares++;
      $display("FAIL log2n0_result: got v=%b d=%h want v=1 d=0100", v0, d0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply(($urandom % 25) == 0, ($urandom % 3) != 0, 8'($urandom));
      vectors++;
      if (act_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_cycle%0d: got %h want %h", i, act_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_rounding();
    test_back_to_back_windows();
    test_clear();
    test_reset_mid_window();
    test_log2n0();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sqrt_msq_acc.md
# sqrt_msq_acc

Mean-square accumulator feeding the SQRT stage. It squares a stream of signed Q4.4 samples, sums 2^LOG2N of them, and emits their mean as an unsigned Q8.8 word with a one-cycle valid strobe. Its output drives SQRT's DATA_IN directly, so SQRT + this block form an RMS unit. Output is held stable between windows so the iterative SQRT can converge on it.

## Interface
- LOG2N, 2, log2 of window length N; legal range 0..8
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- CLEAR  in  1  synchronous window abort, active high
- SAMPLE_VALID  in  1  SAMPLE_IN is valid this cycle
- SAMPLE_IN  in  8  signed two's-complement Q4.4 sample
- DATA_OUT  out  16  unsigned Q8.8 mean of squares; held between windows
- DATA_VALID  out  1  one-cycle pulse when DATA_OUT updates
- BUSY  out  1  high while a window is partially accumulated or a square is in flight

## Operation
- Stage 1, square:
  - On each edge with SAMPLE_VALID=1, register SQ_R = SAMPLE_IN*SAMPLE_IN and set SQ_V=1.
  - SQ_R is 16-bit unsigned Q8.8. Maximum is 0x80*0x80 = 0x4000 (64.0).
  - Edges with SAMPLE_VALID=0 clear SQ_V.
- Stage 2, accumulate:
  - ACC is 16+LOG2N bits wide, so it cannot overflow. CNT is LOG2N bits; with LOG2N=0 there is no counter and every square is the last.
  - On each edge with SQ_V=1 and CNT<N-1: ACC <= ACC+SQ_R and CNT <= CNT+1.
  - On an edge with SQ_V=1 and CNT=N-1 (window complete):
    - DATA_OUT <= (ACC+SQ_R+RND)>>LOG2N, truncated to 16 bits.
    - DATA_VALID <= 1.
    - ACC <= 0 and CNT <= 0.
  - On all other edges, DATA_VALID <= 0.
- Samples may arrive back-to-back every cycle or with arbitrary gaps. Gaps do not affect the result.
- Consecutive windows are seamless: the first square of a new window lands in the ACC that was cleared on the completing edge.
- CLEAR=1 on an edge forces ACC=0, CNT=0 and SQ_V=0, discarding the in-flight square.
  - The sample presented on that same edge is also discarded.
  - DATA_OUT is unchanged and DATA_VALID is 0.
  - CLEAR has priority over all other events.
- BUSY = SQ_V | (CNT!=0).

## Timing
- Reset (RST_N low, asynchronous) forces SQ_R=0, SQ_V=0, ACC=0, CNT=0, DATA_OUT=0x0000, DATA_VALID=0, BUSY=0.
- Release of RST_N is synchronised by the environment. The first sample is accepted on the first rising edge after release.
- Latency: the last sample of a window is sampled on edge k. DATA_OUT and DATA_VALID change on edge k+1 and are visible during the following cycle.
- Throughput: one sample per cycle, with no stall path.
- Reset asserted mid-window aborts the window with no DATA_VALID. The value seen by SQRT drops to 0x0000.
- The downstream SQRT is restarted by its own RST when DATA_VALID fires. DATA_OUT must stay constant for at least 30 cycles, so the system must space windows accordingly. This block does not enforce the spacing.

## Configuration
- MSQ_ROUND_EN:
  - Defined: RND = 2^(LOG2N-1) for LOG2N>0, giving round-half-up. Worst case, 0x4000*N + RND, still shifts to 0x4000, so no overflow.
  - Undefined: RND = 0, giving truncation.
  - LOG2N=0: RND = 0 in both builds.

## Test plan
- LOG2N=2, four samples 0x20 (2.0) back-to-back -> DATA_VALID pulse on the edge after the 4th sample; DATA_OUT=0x0400 (4.0); BUSY low afterwards.
- LOG2N=2, four samples 0x80 (-8.0) with 2-cycle gaps between them -> DATA_OUT=0x4000; exactly one DATA_VALID pulse.
- LOG2N=2, samples 0x10,0x10,0x11,0x11 (sum of squares 0x0442):
  - Without MSQ_ROUND_EN -> DATA_OUT=0x0110.
  - With MSQ_ROUND_EN -> DATA_OUT=0x0111.
- Two windows streamed with no gap (4×0x20 then 4×0x30) -> DATA_OUT 0x0400 then 0x0900; DATA_VALID pulses exactly 4 cycles apart.
- Abort cases, both using 2 samples of 0x20:
  - CLEAR after the 2 samples, then 4×0x10 -> DATA_OUT=0x0100; prior DATA_OUT is held through the CLEAR.
  - RST_N pulsed low after the 2 samples -> all outputs 0 immediately, with no DATA_VALID.
- LOG2N=0, sample 0xF0 (-1.0) -> DATA_VALID on the next edge with DATA_OUT=0x0100. Feeding this to SQRT yields ~0x0100 (1.0).
